// File: rtl/mul_gi_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_gi_seq_if
// Brief    : Operand/result bundle for the sequential g*i lane multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_gi_seq_if #(
    parameter int GW = 14,
    parameter int IW = 8,
    parameter int SH = 6,
    parameter int N  = 121
);
    localparam int OW = GW + IW + SH;
    localparam int SW = OW + $clog2(N);

    logic            start;
    logic            en;
    logic [N*GW-1:0] g_in;
    logic [N*IW-1:0] i_in;
    logic [N*OW-1:0] hold_in;
    logic [N*OW-1:0] out;
    logic [SW-1:0]   sum;
    logic            busy;
    logic            done;

    modport master (
        output start, en, g_in, i_in, hold_in,
        input  out, sum, busy, done
    );

    modport slave (
        input  start, en, g_in, i_in, hold_in,
        output out, sum, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mul_gi_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_gi_seq
// Brief    : Time-multiplexed N-lane g*(i<<SH) multiplier, P lanes per cycle,
//            with running sum and a single-cycle bypass (hold) load.
// Revision : 1.0 - initial release
// ============================================================================
module mul_gi_seq #(
    parameter int GW = 14,
    parameter int IW = 8,
    parameter int SH = 6,
    parameter int N  = 121,
    parameter int P  = 11
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mul_gi_seq_if.slave   bus
);
    localparam int OW = GW + IW + SH;
    localparam int SW = OW + $clog2(N);
    localparam int G  = N / P;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(G - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [N*GW-1:0]  r_g;
    logic [N*IW-1:0]  r_i;
    logic [N*OW-1:0]  r_out;
    logic [SW-1:0]    r_sum;
    logic [OW-1:0]    w_prod [P];
    logic [SW-1:0]    w_grp_sum;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = bus.en ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Zero-extending both operands to OW keeps the full product width.
    always_comb begin
        w_grp_sum = '0;
        for (int p = 0; p < P; p++) begin
            w_prod[p] = {{(OW-GW){1'b0}}, r_g[(int'(r_cnt)*P + p)*GW +: GW]}
                      * {{GW{1'b0}}, r_i[(int'(r_cnt)*P + p)*IW +: IW], {SH{1'b0}}};
            w_grp_sum = w_grp_sum + {{(SW-OW){1'b0}}, w_prod[p]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_g   <= '0;
            r_i   <= '0;
            r_out <= '0;
            r_sum <= '0;
        end else begin
            if (w_accept) begin
                r_sum <= '0;
                if (bus.en) begin
                    r_g   <= bus.g_in;
                    r_i   <= bus.i_in;
                    r_cnt <= '0;
                end else begin
                    r_out <= bus.hold_in;
                end
            end else if (r_state == ST_RUN) begin
                for (int p = 0; p < P; p++) begin
                    r_out[(int'(r_cnt)*P + p)*OW +: OW] <= w_prod[p];
                end
                r_sum <= r_sum + w_grp_sum;
                if (r_cnt != c_cnt_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out  = r_out;
    assign bus.sum  = r_sum;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
endmodule
`default_nettype wire

// File: tb/tb_mul_gi_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_gi_seq
// Brief    : Directed self-checking bench for mul_gi_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_gi_seq;
    localparam int GW = 14;
    localparam int IW = 8;
    localparam int SH = 6;
    localparam int N  = 121;
    localparam int P  = 11;
    localparam int OW = GW + IW + SH;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   busy_cnt;
    int   done_cnt;
    int   done_idx;
    bit   timed_out;

    mul_gi_seq_if #(.GW(GW), .IW(IW), .SH(SH), .N(N)) bus ();

    mul_gi_seq #(.GW(GW), .IW(IW), .SH(SH), .N(N), .P(P)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_uniform(input int g, input int i);
        for (int k = 0; k < N; k++) begin
            bus.g_in[k*GW +: GW] = GW'(g);
            bus.i_in[k*IW +: IW] = IW'(i);
        end
    endtask

    task automatic scramble_ops();
        for (int k = 0; k < N; k++) begin
            bus.g_in[k*GW +: GW] = GW'($urandom);
            bus.i_in[k*IW +: IW] = IW'($urandom);
        end
    endtask

    function automatic logic [OW-1:0] lane(input int k);
        return bus.out[k*OW +: OW];
    endfunction

    // Expected lane k value is base + k*mult.
    task automatic check_lanes(input string tag, input longint base, input longint mult);
        int nbad = 0;
        for (int k = 0; k < N; k++) begin
            if (64'(lane(k)) != 64'(base + longint'(k) * mult)) nbad++;
        end
        chk(tag, 64'(nbad), 64'd0);
    endtask

    task automatic run_op(input bit en_v, input bit hold_start, input bit scramble);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_idx  = -1;
        timed_out = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.en    = en_v;
        @(posedge clk);
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge clk);
            if (!hold_start) bus.start = 1'b0;
            if (scramble) scramble_ops();
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_idx = idx;
            end
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.en      = 1'b0;
        bus.g_in    = '0;
        bus.i_in    = '0;
        bus.hold_in = '0;

        repeat (3) @(negedge clk);
        chk("rst_out", 64'(|bus.out), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // All ones: 1 * (1<<6) per lane.
        set_uniform(1, 1);
        run_op(1'b1, 1'b0, 1'b0);
        chk("ones_timeout", 64'(timed_out), 64'd0);
        chk("ones_busy_cycles", 64'(busy_cnt), 64'd12);
        chk("ones_done_cnt", 64'(done_cnt), 64'd1);
        chk("ones_done_idx", 64'(done_idx), 64'd11);
        check_lanes("ones_lanes", 64, 0);
        chk("ones_sum", 64'(bus.sum), 64'd7744);

        // Full-scale operands: 16383 * 16320 per lane, no wrap in OW or SW.
        set_uniform(16383, 255);
        run_op(1'b1, 1'b0, 1'b0);
        chk("max_done_cnt", 64'(done_cnt), 64'd1);
        check_lanes("max_lanes", 267370560, 0);
        chk("max_sum", 64'(bus.sum), 64'd32351837760);
        set_uniform(0, 0);
        repeat (3) @(negedge clk);
        chk("idle_sum_stable", 64'(bus.sum), 64'd32351837760);
        chk("idle_lane_stable", 64'(lane(77)), 64'd267370560);

        // Bypass: lane k loads k, DONE right after accept, no RUN cycles.
        for (int k = 0; k < N; k++) bus.hold_in[k*OW +: OW] = OW'(k);
        run_op(1'b0, 1'b0, 1'b0);
        chk("byp_busy_cycles", 64'(busy_cnt), 64'd1);
        chk("byp_done_idx", 64'(done_idx), 64'd0);
        check_lanes("byp_lanes", 0, 1);
        chk("byp_sum", 64'(bus.sum), 64'd0);

        // Ramp g=k, i=2: lanes fill one group per RUN edge.
        for (int k = 0; k < N; k++) begin
            bus.g_in[k*GW +: GW] = GW'(k);
            bus.i_in[k*IW +: IW] = IW'(2);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("ramp_l10_pre", 64'(lane(10)), 64'd10);
        @(negedge clk);
        chk("ramp_l10_edge1", 64'(lane(10)), 64'd1280);
        chk("ramp_l11_edge1", 64'(lane(11)), 64'd11);
        chk("ramp_l120_edge1", 64'(lane(120)), 64'd120);
        repeat (9) @(negedge clk);
        chk("ramp_l120_edge10", 64'(lane(120)), 64'd120);
        @(negedge clk);
        chk("ramp_l120_edge11", 64'(lane(120)), 64'd15360);
        chk("ramp_done", 64'(bus.done), 64'd1);
        @(negedge clk);
        chk("ramp_idle", 64'(bus.busy), 64'd0);
        check_lanes("ramp_lanes", 0, 128);
        chk("ramp_sum", 64'(bus.sum), 64'd929280);

        // start held high, operands scrambled after accept.
        set_uniform(5, 7);
        run_op(1'b1, 1'b1, 1'b1);
        chk("hold_timeout", 64'(timed_out), 64'd0);
        chk("hold_done_cnt", 64'(done_cnt), 64'd1);
        chk("hold_done_idx", 64'(done_idx), 64'd11);
        check_lanes("hold_lanes", 2240, 0);
        chk("hold_sum", 64'(bus.sum), 64'd271040);
        @(negedge clk);
        chk("hold_reaccept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        timed_out = 1'b1;
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge clk);
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("hold2_timeout", 64'(timed_out), 64'd0);

        // Asynchronous abort at RUN cycle 5.
        set_uniform(1, 1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_busy", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out", 64'(|bus.out), 64'd0);
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        done_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        rst = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        set_uniform(3, 1);
        run_op(1'b1, 1'b0, 1'b0);
        chk("post_done_idx", 64'(done_idx), 64'd11);
        check_lanes("post_lanes", 192, 0);
        chk("post_sum", 64'(bus.sum), 64'd23232);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
